// File: rtl/tricolor_pwm_ctrl.sv
// tricolor_pwm_ctrl: debounced two-button colour/brightness controller
// driving an active-low RGB LED with one shared PWM period.
module tricolor_pwm_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned PWM_BITS        = 8,
  parameter int unsigned BRIGHT_STEP     = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_btn_a,
  input  logic                i_btn_b,
  output logic                o_led_r,
  output logic                o_led_g,
  output logic                o_led_b,
  output logic [2:0]          o_state,
  output logic [PWM_BITS-1:0] o_duty
);

  localparam int unsigned          NUM_BTN  = 2;
  localparam int unsigned          DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]      DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PWM_BITS-1:0]  DUTY_MAX = '1;
  localparam logic [PWM_BITS:0]    STEP_EXT = (PWM_BITS + 1)'(BRIGHT_STEP);
  localparam logic [PWM_BITS-1:0]  STEP_VAL = PWM_BITS'(BRIGHT_STEP);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_RED   = 3'd1,
    ST_GREEN = 3'd2,
    ST_BLUE  = 3'd3,
    ST_WHITE = 3'd4
  } state_t;

  // Index 0 is button A, index 1 is button B.
  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_stable;
  logic [NUM_BTN-1:0] r_stable_d;
  logic [NUM_BTN-1:0] r_press;
  logic [DB_W-1:0]    r_db_cnt [NUM_BTN];

  state_t             r_state;
  state_t             w_state_next;
  logic               w_en_r;
  logic               w_en_g;
  logic               w_en_b;

  logic [PWM_BITS-1:0] r_duty_next;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS:0]   w_duty_sum;
  logic [PWM_BITS-1:0] w_duty_bumped;
  logic                w_lit;

  logic r_led_r;
  logic r_led_g;
  logic r_led_b;

  assign w_btn_raw = {i_btn_b, i_btn_a};

  // Two-flop synchronizers; released level (1) out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: a new level is accepted only after holding for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable <= '1;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // One-cycle press pulse on an accepted 1->0 transition only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable_d <= '1;
      r_press    <= '0;
    end else begin
      r_stable_d <= r_stable;
      r_press    <= r_stable_d & ~r_stable;
    end
  end

  // Colour state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Colour next-state and channel enables; illegal codes fall back to OFF.
  always_comb begin
    w_state_next = r_state;
    w_en_r       = 1'b0;
    w_en_g       = 1'b0;
    w_en_b       = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (r_press[0]) w_state_next = ST_RED;
      end
      ST_RED: begin
        w_en_r = 1'b1;
        if (r_press[0]) w_state_next = ST_GREEN;
      end
      ST_GREEN: begin
        w_en_g = 1'b1;
        if (r_press[0]) w_state_next = ST_BLUE;
      end
      ST_BLUE: begin
        w_en_b = 1'b1;
        if (r_press[0]) w_state_next = ST_WHITE;
      end
      ST_WHITE: begin
        w_en_r = 1'b1;
        w_en_g = 1'b1;
        w_en_b = 1'b1;
        if (r_press[0]) w_state_next = ST_OFF;
      end
      default: begin
        w_state_next = ST_OFF;
      end
    endcase
  end

  // Brightness step with carry detection; an overflow restarts at one step, never 0.
  always_comb begin
    w_duty_sum    = {1'b0, r_duty_next} + STEP_EXT;
    w_duty_bumped = w_duty_sum[PWM_BITS] ? STEP_VAL : w_duty_sum[PWM_BITS-1:0];
  end

  // Pending duty, updated on each button-B press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duty_next <= DUTY_MAX;
    end else if (r_press[1]) begin
      r_duty_next <= w_duty_bumped;
    end
  end

  // Free-running PWM counter; active duty only reloads at the period wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_duty <= DUTY_MAX;
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
      if (r_cnt == DUTY_MAX) begin
        r_duty <= r_duty_next;
      end
    end
  end

  assign w_lit = (r_cnt < r_duty);

  // Registered active-low LED drive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led_r <= 1'b1;
      r_led_g <= 1'b1;
      r_led_b <= 1'b1;
    end else begin
      r_led_r <= ~(w_en_r & w_lit);
      r_led_g <= ~(w_en_g & w_lit);
      r_led_b <= ~(w_en_b & w_lit);
    end
  end

  assign o_led_r = r_led_r;
  assign o_led_g = r_led_g;
  assign o_led_b = r_led_b;
  assign o_state = r_state;
  assign o_duty  = r_duty;

endmodule

// File: tb/tb_tricolor_pwm_ctrl.sv
// Bench for tricolor_pwm_ctrl: event-level reference model plus directed and random stimulus.
`timescale 1ns/1ps
module tb_tricolor_pwm_ctrl;

  localparam int DB   = 4;
  localparam int PB   = 4;
  localparam int STEP = 4;
  localparam int PER  = 16;
  localparam int MAXD = 15;
  localparam int HN   = 8192;

  logic       clk;
  logic       rst_n;
  logic       btn_a;
  logic       btn_b;
  logic       led_r;
  logic       led_g;
  logic       led_b;
  logic [2:0] state;
  logic [PB-1:0] duty;

  tricolor_pwm_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .PWM_BITS       (PB),
    .BRIGHT_STEP    (STEP)
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_btn_a(btn_a),
    .i_btn_b(btn_b),
    .o_led_r(led_r),
    .o_led_g(led_g),
    .o_led_b(led_b),
    .o_state(state),
    .o_duty (duty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pin history per clock edge since reset, acceptance by run length,
  // press effects scheduled two edges after acceptance, PWM phase from the edge count.
  int m_n;
  bit m_ha [HN];
  bit m_hb [HN];
  bit m_ea [HN];
  bit m_eb [HN];
  bit m_st_a, m_st_b;
  int m_state, m_dnext, m_duty;
  logic [2:0] m_led;

  function automatic logic [2:0] enables(input int s);
    case (s)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      4: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int bump(input int d);
    if (d + STEP > MAXD) return STEP;
    return d + STEP;
  endfunction

  function automatic bit pin_at(input int which, input int k);
    if (k < 1) return 1'b1;
    return (which == 0) ? m_ha[k] : m_hb[k];
  endfunction

  // True when the last DB synchronized samples all differ from the stable level.
  function automatic bit run_diff(input int which, input int n, input bit st);
    for (int k = n - 1 - DB; k <= n - 2; k++) begin
      if (pin_at(which, k) == st) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0;
      m_st_a = 1'b1;
      m_st_b = 1'b1;
      m_state = 0;
      m_dnext = MAXD;
      m_duty = MAXD;
      m_led = 3'b111;
      for (int i = 0; i < HN; i++) begin
        m_ea[i] = 1'b0;
        m_eb[i] = 1'b0;
      end
    end else begin
      m_n++;
      if (m_n >= HN - 3) begin
        $display("FAIL model_bound: got %0d expected below %0d", m_n, HN - 3);
        $fatal(1, "model history exhausted");
      end
      m_ha[m_n] = btn_a;
      m_hb[m_n] = btn_b;
      m_led = ~(enables(m_state) & {3{(((m_n - 1) % PER) < m_duty)}});
      if (((m_n - 1) % PER) == PER - 1) m_duty = m_dnext;
      if (m_ea[m_n]) m_state = (m_state + 1) % 5;
      if (m_eb[m_n]) m_dnext = bump(m_dnext);
      if (run_diff(0, m_n, m_st_a)) begin
        m_st_a = ~m_st_a;
        if (!m_st_a) m_ea[m_n + 2] = 1'b1;
      end
      if (run_diff(1, m_n, m_st_b)) begin
        m_st_b = ~m_st_b;
        if (!m_st_b) m_eb[m_n + 2] = 1'b1;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("state", int'(state), m_state);
      check("duty", int'(duty), m_duty);
      check("leds", int'({led_r, led_g, led_b}), int'(m_led));
    end
  end

  task automatic drive(input bit a, input bit b, input int cycles);
    btn_a = a;
    btn_b = b;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic count_low(output int cr, output int cg, output int cb);
    cr = 0; cg = 0; cb = 0;
    repeat (PER) begin
      @(negedge clk);
      cr += int'(!led_r);
      cg += int'(!led_g);
      cb += int'(!led_b);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_leds", int'({led_r, led_g, led_b}), 7);
    check("rst_state", int'(state), 0);
    check("rst_duty", int'(duty), MAXD);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_duty [4];
  int cr, cg, cb;

  initial begin
    rst_n = 1'b0;
    btn_a = 1'b1;
    btn_b = 1'b1;
    repeat (3) @(negedge clk);
    check("init_state", int'(state), 0);
    check("init_duty", int'(duty), MAXD);
    check("init_leds", int'({led_r, led_g, led_b}), 7);
    rst_n = 1'b1;
    chk_en = 1'b1;
    drive(1, 1, 5);

    // Five clean A presses cycle back to OFF.
    repeat (5) begin
      drive(0, 1, 10);
      drive(1, 1, 10);
    end
    check("a5_state", int'(state), 0);

    // Short bounces are rejected; a long enough hold steps once.
    drive(0, 1, 3); drive(1, 1, 2); drive(0, 1, 3); drive(1, 1, 10);
    check("bounce_state", int'(state), 0);
    drive(0, 1, 6); drive(1, 1, 10);
    check("bounce_step", int'(state), 1);

    // Brightness steps in RED: 15 -> 4 (carry) -> 8 -> 12 -> 4 (carry).
    exp_duty = '{4, 8, 12, 4};
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 10);
      drive(1, 1, 18);
      check("b_duty", int'(duty), exp_duty[i]);
    end
    count_low(cr, cg, cb);
    check("red_on_r", cr, 4);
    check("red_on_g", cg, 0);
    check("red_on_b", cb, 0);

    // Move to WHITE, step to duty 8, and measure all three channels.
    repeat (3) begin
      drive(0, 1, 10);
      drive(1, 1, 10);
    end
    check("white_state", int'(state), 4);
    drive(1, 0, 10);
    drive(1, 1, 20);
    count_low(cr, cg, cb);
    check("white_on_r", cr, 8);
    check("white_on_g", cg, 8);
    check("white_on_b", cb, 8);

    // Mid-run async reset, then simultaneous A and B presses.
    async_reset();
    drive(0, 0, 10);
    drive(1, 1, 20);
    check("ab_state", int'(state), 1);
    check("ab_duty", int'(duty), 4);

    // Random bounce/press segments on both buttons.
    for (int s = 0; s < 300; s++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
      if (s == 150) async_reset();
    end
    drive(1, 1, 40);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
